// File: rtl/data_plane_tx.sv
// data_plane_tx: buffers GPP frames in a FIFO and serialises one frame per control-plane grant
module data_plane_tx #(
  parameter int DEPTH = 64,
  parameter int FRAME_WORDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic        gpp_trf_en,
  input  logic [15:0] gpp_trf_data,
  input  logic        data_tx_flag,
  output logic [15:0] RAM_tx_data_out,
  output logic [15:0] sp_tx_current,
  output logic [31:0] data_tx_packet,
  output logic        data_tx_valid,
  output logic        data_tx_complete_flag,
  output logic        tx_full,
  output logic        tx_overflow
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BW = FRAME_WORDS > 2 ? $clog2(FRAME_WORDS) : 1;
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2, WAIT_CLR = 2'd3;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0] count;
  logic [1:0] state;
  logic [BW-1:0] beat;
  logic empty, push, pop;
  assign empty = count == 16'd0;
  assign tx_full = count == 16'(DEPTH);
  assign pop = !empty && ((state == IDLE && data_tx_flag) || state == SEND);
  // a push into a full FIFO is still accepted when the same cycle frees a slot
  assign push = gpp_trf_en && (!tx_full || pop);
  assign RAM_tx_data_out = empty ? 16'h0000 : mem[rd_ptr];
  assign sp_tx_current = count;
  // storage array write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gpp_trf_data;
  end
  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= 16'd0;
      tx_overflow <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + {15'd0, push} - {15'd0, pop};
      tx_overflow <= tx_overflow || (gpp_trf_en && !push);
    end
  end
  // frame sequencer: header pop, payload beats with underflow stall, complete pulse, wait for grant drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      data_tx_packet <= 32'd0;
      data_tx_valid <= 1'b0;
      data_tx_complete_flag <= 1'b0;
    end else begin
      data_tx_valid <= 1'b0;
      data_tx_complete_flag <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          beat <= '0;
          state <= SEND;
        end
        SEND: if (pop) begin
          data_tx_packet <= {node_id, RAM_tx_data_out};
          data_tx_valid <= 1'b1;
          beat <= beat + BW'(1);
          state <= beat == BW'(FRAME_WORDS - 2) ? DONE : SEND;
        end
        DONE: begin
          data_tx_complete_flag <= 1'b1;
          state <= WAIT_CLR;
        end
        default: state <= data_tx_flag ? WAIT_CLR : IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_plane_tx.sv
// tb_data_plane_tx: queue-based reference model plus directed frames for data_plane_tx
module tb_data_plane_tx;
  logic clk = 0, rst = 1, en = 0, flag = 0;
  logic [15:0] node_id = 16'h0007, data = 16'h0000;
  logic [15:0] ram, sp;
  logic [31:0] pkt;
  logic valid, cmp, full, ovf;
  int tests = 0, fails = 0;
  logic [15:0] q[$];
  bit m_ovf, armed, took;
  int phase, sent, pre;
  logic e_valid, e_cmp;
  logic [31:0] e_pkt;
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  int cmp_cnt = 0;

  data_plane_tx #(.DEPTH(64), .FRAME_WORDS(5)) dut (
    .clk(clk), .rst(rst), .node_id(node_id), .gpp_trf_en(en), .gpp_trf_data(data),
    .data_tx_flag(flag), .RAM_tx_data_out(ram), .sp_tx_current(sp), .data_tx_packet(pkt),
    .data_tx_valid(valid), .data_tx_complete_flag(cmp), .tx_full(full), .tx_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: phase 0 waits for a grant, 1 collects 4 payload words, 2 owes the complete pulse, 3 waits for the grant to drop
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete(); m_ovf = 0; phase = 0; sent = 0;
      e_valid = 0; e_cmp = 0; e_pkt = 0; armed = 1;
    end else begin
      pre = q.size(); took = 0; e_valid = 0; e_cmp = 0;
      if (phase == 0) begin
        if (flag && pre > 0) begin void'(q.pop_front()); took = 1; phase = 1; sent = 0; end
      end else if (phase == 1) begin
        if (pre > 0) begin
          e_pkt = {node_id, q.pop_front()}; took = 1; e_valid = 1; sent++;
          if (sent == 4) phase = 2;
        end
      end else if (phase == 2) begin
        e_cmp = 1; phase = 3;
      end else if (!flag) phase = 0;
      if (en) begin
        if (pre < 64 || took) q.push_back(data);
        else m_ovf = 1;
      end
    end
  end

  // Compare every cycle once the first reset has been seen
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("sp_tx_current", {16'd0, sp}, 32'(q.size()));
      chk("head", {16'd0, ram}, {16'd0, q.size() > 0 ? q[0] : 16'h0000});
      chk("tx_full", {31'd0, full}, {31'd0, q.size() == 64});
      chk("tx_overflow", {31'd0, ovf}, {31'd0, m_ovf});
      chk("valid", {31'd0, valid}, {31'd0, e_valid});
      chk("complete", {31'd0, cmp}, {31'd0, e_cmp});
      chk("packet", pkt, e_pkt);
      if (valid === 1'b1) log_q.push_back(pkt);
      if (cmp === 1'b1) cmp_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    en = 1; data = w;
    tick();
    en = 0;
  endtask

  task automatic push_frame(input logic [15:0] base);
    push(16'h0003);
    for (int i = 0; i < 4; i++) push(base + 16'(i));
  endtask

  task automatic wait_cmp(input int n, input string name);
    int t = 0;
    while (cmp_cnt < n && t < 60) begin tick(); t++; end
    if (cmp_cnt < n) chk({name, "_timeout"}, 32'(cmp_cnt), 32'(n));
  endtask

  task automatic chk_frame(input string name, input logic [15:0] base);
    chk({name, "_beats"}, 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_beat%0d", name, i + 1), i < log_q.size() ? log_q[i] : 32'hx, {16'h0007, base + 16'(i)});
  endtask

  task automatic reset_dut;
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    reset_dut();
    chk("rst_sp", {16'd0, sp}, 32'd0);
    chk("rst_head", {16'd0, ram}, 32'd0);
    chk("rst_pkt", pkt, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    push_frame(16'hA001);
    chk("push_sp", {16'd0, sp}, 32'd5);
    chk("push_head", {16'd0, ram}, 32'h0003);
    chk("push_quiet", 32'(log_q.size() + cmp_cnt), 32'd0);
    flag = 1;
    wait_cmp(1, "f1");
    tick();
    chk_frame("f1", 16'hA001);
    chk("f1_sp", {16'd0, sp}, 32'd0);
    push_frame(16'hB001);
    repeat (8) tick();
    chk("stale_grant_beats", 32'(log_q.size()), 32'd4);
    chk("stale_grant_cmp", 32'(cmp_cnt), 32'd1);
    chk("stale_grant_sp", {16'd0, sp}, 32'd5);
    flag = 0; tick();
    log_q.delete(); cmp_cnt = 0;
    flag = 1;
    wait_cmp(1, "f2");
    tick();
    chk_frame("f2", 16'hB001);
    flag = 0; tick(); tick();
    log_q.delete(); cmp_cnt = 0;
    push(16'h0003); push(16'hC001); push(16'hC002);
    flag = 1;
    repeat (4) tick();
    chk("stall_valid", {31'd0, valid}, 32'd0);
    chk("stall_beats", 32'(log_q.size()), 32'd2);
    repeat (3) tick();
    push(16'hC003); push(16'hC004);
    wait_cmp(1, "uf");
    repeat (5) tick();
    chk_frame("uf", 16'hC001);
    chk("uf_cmp_once", 32'(cmp_cnt), 32'd1);
    flag = 0; tick(); tick();
    reset_dut();
    for (int i = 0; i < 65; i++) push(16'(i));
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_sp", {16'd0, sp}, 32'd64);
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    flag = 1; en = 1; data = 16'hFFFF;
    tick();
    en = 0; flag = 0;
    chk("pushpop_full_sp", {16'd0, sp}, 32'd64);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    reset_dut();
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    log_q.delete(); cmp_cnt = 0;
    push_frame(16'hD001);
    flag = 1;
    for (int t = 0; t < 30 && log_q.size() < 2; t++) tick();
    rst = 1; tick(); rst = 0; flag = 0;
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_sp", {16'd0, sp}, 32'd0);
    repeat (10) tick();
    chk("midrst_no_cmp", 32'(cmp_cnt), 32'd0);
    log_q.delete();
    flag = 1;
    push_frame(16'hE001);
    wait_cmp(1, "fresh");
    tick();
    chk_frame("fresh", 16'hE001);
    flag = 0; tick(); tick();
    log_q.delete(); cmp_cnt = 0;
    for (int f = 0; f < 30; f++) begin
      flag = 1;
      push(16'h0003);
      for (int i = 1; i <= 4; i++) begin
        push(16'h5000 + 16'(f * 4 + i));
        exp_q.push_back({16'h0007, 16'h5000 + 16'(f * 4 + i)});
      end
      wait_cmp(f + 1, "wrap");
      flag = 0; tick(); tick();
    end
    chk("wrap_beats", 32'(log_q.size()), 32'd120);
    for (int i = 0; i < 120; i++)
      chk($sformatf("wrap_beat%0d", i), i < log_q.size() ? log_q[i] : 32'hx, exp_q[i]);
    chk("wrap_cmp", 32'(cmp_cnt), 32'd30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
